keccak_obi_slave: RTL and testbench

KECCAK_OBI_SLAVE -- requirements
Module: keccak_obi_slave

---
 rtl/keccak_x_heep_pkg.sv | 46 ++++
 rtl/keccak_obi_slave_if.sv | 10 +
 rtl/keccak_obi_slave.sv | 128 ++++++++++++
 tb/tb_keccak_obi_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_x_heep_pkg.sv
// Shared definitions for the Keccak OBI slave: register offsets, FSM states,
// OBI bus structs and the byte-enable merge helper.
package keccak_x_heep_pkg;

  localparam int NUM_WORDS = 50;

  localparam logic [31:0] OFF_DIN       = 32'h000;
  localparam logic [31:0] OFF_DOUT      = 32'h100;
  localparam logic [31:0] OFF_CTRL      = 32'h200;
  localparam logic [31:0] OFF_STATUS    = 32'h204;
  localparam logic [31:0] OFF_INTR_EN   = 32'h208;
  localparam logic [31:0] OFF_INTR_STAT = 32'h20C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } keccak_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Bytes whose enable is low keep their old contents.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/keccak_obi_slave_if.sv
// OBI request/response bundle between ext_bus and the Keccak register slave.
interface keccak_obi_slave_if;
  import keccak_x_heep_pkg::*;

  obi_req_t  req;
  obi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/keccak_obi_slave.sv
// Zero-wait-state OBI register slave that stages the Keccak state, launches the
// permutation core, captures its result and raises a maskable interrupt.
module keccak_obi_slave #(
  parameter int NUM_WORDS = keccak_x_heep_pkg::NUM_WORDS,
  parameter int OFFSET_W  = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  keccak_x_heep_pkg::obi_req_t   slave_req_i,
  output keccak_x_heep_pkg::obi_resp_t  slave_resp_o,
  output logic [32*NUM_WORDS-1:0]       din_o,
  output logic                          start_o,
  input  logic [32*NUM_WORDS-1:0]       dout_i,
  input  logic                          done_i,
  output logic                          intr_o
);
  import keccak_x_heep_pkg::*;

  keccak_state_e r_state, w_state_nxt;

  logic [31:0] r_din  [NUM_WORDS];
  logic [31:0] r_dout [NUM_WORDS];
  logic        r_intr_en, r_intr_stat, r_intr, r_start;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic [31:0] w_off, w_din_word, w_dout_word, w_rdata;
  logic        w_wr, w_rd, w_din_hit, w_dout_hit;
  logic        w_start_req, w_capture, w_stat_clr;
  logic        w_intr_en_nxt, w_intr_stat_nxt;

  assign w_off       = 32'(slave_req_i.addr[OFFSET_W-1:0]);
  assign w_wr        = slave_req_i.req & slave_req_i.we;
  assign w_rd        = slave_req_i.req & ~slave_req_i.we;
  assign w_din_hit   = (w_off < 32'(NUM_WORDS*4));
  assign w_dout_hit  = (w_off >= OFF_DOUT) && (w_off < OFF_DOUT + 32'(NUM_WORDS*4));
  assign w_din_word  = w_off >> 2;
  assign w_dout_word = (w_off - OFF_DOUT) >> 2;

  assign w_start_req = w_wr && (w_off == OFF_CTRL) && slave_req_i.wdata[0]
                       && slave_req_i.be[0] && (r_state != BUSY);
  assign w_capture   = (r_state == BUSY) && done_i;
  assign w_stat_clr  = w_wr && (w_off == OFF_INTR_STAT) && slave_req_i.wdata[0];

  assign w_intr_en_nxt   = (w_wr && (w_off == OFF_INTR_EN) && slave_req_i.be[0])
                           ? slave_req_i.wdata[0] : r_intr_en;
  // A completion in the same cycle as a clear must leave the flag set.
  assign w_intr_stat_nxt = w_capture ? 1'b1 : (w_stat_clr ? 1'b0 : r_intr_stat);

  assign slave_resp_o.gnt    = slave_req_i.req;
  assign slave_resp_o.rvalid = r_rvalid;
  assign slave_resp_o.rdata  = r_rdata;
  assign start_o             = r_start;
  assign intr_o              = r_intr;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_din
    assign din_o[32*g +: 32] = r_din[g];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_req) w_state_nxt = BUSY;
      BUSY:       if (done_i)      w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_din_hit  && (w_din_word  == 32'(i))) w_rdata = r_din[i];
        if (w_dout_hit && (w_dout_word == 32'(i))) w_rdata = r_dout[i];
      end
      case (w_off)
        OFF_STATUS:    w_rdata = {30'b0, r_state == DONE, r_state == BUSY};
        OFF_INTR_EN:   w_rdata = {31'b0, r_intr_en};
        OFF_INTR_STAT: w_rdata = {31'b0, r_intr_stat};
        default:       ;
      endcase
    end
  end

  // Staged input words; frozen while the core owns the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) r_din[i] <= '0;
    end else if (w_wr && w_din_hit && (r_state != BUSY)) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_din_word == 32'(i))
          r_din[i] <= be_merge(r_din[i], slave_req_i.wdata, slave_req_i.be);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) r_dout[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NUM_WORDS; i++) r_dout[i] <= dout_i[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_intr_en   <= 1'b0;
      r_intr_stat <= 1'b0;
      r_intr      <= 1'b0;
      r_start     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_intr_en   <= w_intr_en_nxt;
      r_intr_stat <= w_intr_stat_nxt;
      r_intr      <= w_intr_stat_nxt & w_intr_en_nxt;
      r_start     <= w_start_req;
      r_rvalid    <= slave_req_i.req;
      r_rdata     <= w_rdata;
    end
  end

endmodule

// File: tb/tb_keccak_obi_slave.sv
// Scoreboard bench for keccak_obi_slave: directed OBI traffic, a behavioural
// stand-in for the Keccak core, and a monitor that checks every rvalid.
module tb_keccak_obi_slave;
  import keccak_x_heep_pkg::*;

  localparam int NW = 50;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [32*NW-1:0]    din_o;
  logic [32*NW-1:0]    dout_i;
  logic                start_o, done_i, intr_o;
  keccak_obi_slave_if  bus();

  exp_t        sb[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic        prevGnt = 1'b0;

  keccak_obi_slave #(.NUM_WORDS(NW), .OFFSET_W(12)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slave_req_i (bus.req),
    .slave_resp_o(bus.resp),
    .din_o       (din_o),
    .start_o     (start_o),
    .dout_i      (dout_i),
    .done_i      (done_i),
    .intr_o      (intr_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request one cycle at a time; the expected rdata goes to the scoreboard.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    bus.req.req   = 1'b1;
    bus.req.we    = we;
    bus.req.addr  = addr;
    bus.req.wdata = wdata;
    bus.req.be    = be;
    sb.push_back('{name, exp});
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b1, addr, data, be, 32'h0, $sformatf("wr_%03h", addr[11:0]));
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, addr, 32'h0, 4'hF, exp, name);
  endtask

  task automatic busIdle();
    @(posedge clk); #1;
    bus.req.req = 1'b0;
    bus.req.we  = 1'b0;
  endtask

  task automatic coreDone(input logic [31:0] base);
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) dout_i[32*i +: 32] = base + 32'(i);
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
  endtask

  task automatic printSummary();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
  endtask

  // Monitor: rvalid must follow each grant by one cycle, and its data must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevGnt = 1'b0;
      sb.delete();
    end else begin
      if (prevGnt || bus.resp.rvalid)
        checkOutput("rvalid_timing", 32'(bus.resp.rvalid), 32'(prevGnt));
      if (bus.resp.rvalid) begin
        if (sb.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'(bus.resp.rvalid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput(e.name, bus.resp.rdata, e.data);
        end
      end
      prevGnt = bus.resp.gnt;
    end
  end

  initial begin
    #2_000_000;
    nFails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    done_i        = 1'b0;
    dout_i        = '0;
    bus.req.req   = 1'b0;
    bus.req.we    = 1'b0;
    bus.req.be    = 4'h0;
    bus.req.addr  = '0;
    bus.req.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_start_o", 32'(start_o), 32'h0);
    checkOutput("reset_intr_o", 32'(intr_o), 32'h0);
    checkOutput("reset_rvalid", 32'(bus.resp.rvalid), 32'h0);
    checkOutput("reset_din_o", 32'(din_o != '0), 32'h0);
    rst_n = 1'b1;

    // Fill and read back the whole input state.
    for (int i = 0; i < NW; i++) writeReg(OFF_DIN + 32'(4*i), 32'(i), 4'hF);
    for (int i = 0; i < NW; i++) readReg(OFF_DIN + 32'(4*i), 32'(i), $sformatf("din_rd_%0d", i));
    busIdle();
    checkOutput("din_o_word7", din_o[32*7 +: 32], 32'd7);

    // Byte-enable merge, unmapped read, write to a read-only register.
    writeReg(OFF_DIN + 32'd20, 32'h0, 4'hF);
    writeReg(OFF_DIN + 32'd20, 32'h1234AB56, 4'b0010);
    readReg(OFF_DIN + 32'd20, 32'h0000AB00, "din5_be");
    readReg(32'h300, 32'h0, "unmapped_rd");
    writeReg(OFF_STATUS, 32'hFFFF_FFFF, 4'hF);
    readReg(OFF_STATUS, 32'h0, "status_idle");
    writeReg(OFF_INTR_EN, 32'h1, 4'h1);
    readReg(OFF_INTR_EN, 32'h1, "intr_en_rd");

    // First permutation.
    writeReg(OFF_CTRL, 32'h1, 4'h1);
    busIdle();
    checkOutput("start_pulse", 32'(start_o), 32'h1);
    readReg(OFF_STATUS, 32'h1, "status_busy");
    checkOutput("start_one_cycle", 32'(start_o), 32'h0);
    writeReg(OFF_DIN + 32'd12, 32'hFFFF_FFFF, 4'hF);
    writeReg(OFF_CTRL, 32'h1, 4'h1);
    busIdle();
    checkOutput("no_restart", 32'(start_o), 32'h0);
    readReg(OFF_DIN + 32'd12, 32'd3, "din3_busy");
    readReg(OFF_DOUT + 32'd28, 32'h0, "dout7_prev");
    busIdle();
    checkOutput("no_restart_late", 32'(start_o), 32'h0);
    coreDone(32'hA5A5_0000);
    checkOutput("intr_after_done", 32'(intr_o), 32'h1);
    readReg(OFF_STATUS, 32'h2, "status_done");
    readReg(OFF_DOUT + 32'd28, 32'hA5A5_0007, "dout7");
    readReg(OFF_DOUT + 32'd196, 32'hA5A5_0031, "dout49");
    readReg(OFF_INTR_STAT, 32'h1, "intr_stat_set");
    busIdle();

    // done_i outside BUSY is ignored.
    coreDone(32'h1234_0000);
    readReg(OFF_DOUT + 32'd28, 32'hA5A5_0007, "dout7_stray_done");
    writeReg(OFF_INTR_STAT, 32'h1, 4'h1);
    busIdle();
    checkOutput("intr_cleared", 32'(intr_o), 32'h0);
    readReg(OFF_INTR_STAT, 32'h0, "intr_stat_clr");

    // Interrupt masked, restart from DONE.
    writeReg(OFF_INTR_EN, 32'h0, 4'h1);
    writeReg(OFF_CTRL, 32'h1, 4'h1);
    busIdle();
    checkOutput("start_from_done", 32'(start_o), 32'h1);
    readReg(OFF_STATUS, 32'h1, "status_rebusy");
    busIdle();
    coreDone(32'h5A5A_0000);
    checkOutput("intr_masked", 32'(intr_o), 32'h0);
    readReg(OFF_INTR_STAT, 32'h1, "intr_stat_masked");
    readReg(OFF_DOUT + 32'd28, 32'h5A5A_0007, "dout7_second");
    writeReg(OFF_INTR_STAT, 32'h1, 4'h1);
    readReg(OFF_INTR_STAT, 32'h0, "intr_stat_clr2");

    // Completion and clear in the same cycle: the set wins.
    writeReg(OFF_CTRL, 32'h1, 4'h1);
    busIdle();
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) dout_i[32*i +: 32] = 32'h0F0F_0000 + 32'(i);
    done_i        = 1'b1;
    bus.req.req   = 1'b1;
    bus.req.we    = 1'b1;
    bus.req.addr  = OFF_INTR_STAT;
    bus.req.wdata = 32'h1;
    bus.req.be    = 4'h1;
    sb.push_back('{"wr_clr_vs_set", 32'h0});
    @(posedge clk); #1;
    done_i = 1'b0;
    bus.req.req = 1'b0;
    readReg(OFF_INTR_STAT, 32'h1, "set_wins");
    readReg(OFF_STATUS, 32'h2, "status_done3");

    // Reset in the middle of an operation.
    writeReg(OFF_INTR_EN, 32'h1, 4'h1);
    writeReg(OFF_CTRL, 32'h1, 4'h1);
    busIdle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_intr_o", 32'(intr_o), 32'h0);
    checkOutput("rst_start_o", 32'(start_o), 32'h0);
    checkOutput("rst_rvalid_drop", 32'(bus.resp.rvalid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    coreDone(32'hDEAD_0000);
    checkOutput("rst_intr_after_done", 32'(intr_o), 32'h0);
    readReg(OFF_STATUS, 32'h0, "rst_status");
    readReg(OFF_DOUT + 32'd28, 32'h0, "rst_dout7");
    readReg(OFF_DOUT, 32'h0, "rst_dout0");
    readReg(OFF_DIN + 32'd20, 32'h0, "rst_din5");
    readReg(OFF_INTR_STAT, 32'h0, "rst_intr_stat");
    busIdle();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);
    printSummary();
    $finish;
  end

endmodule
